wb_stage_grf: RTL and testbench



---
 rtl/wb_stage_grf.sv | 151 +++++++++++++++
 tb/tb_wb_stage_grf.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_grf.sv
// -----------------------------------------------------------------------------
// wb_stage_grf
//   Writeback stage plus 32x32 general register file for the 5-stage MIPS
//   pipeline. Extends load data, selects the writeback value, writes the GRF,
//   serves the two D-stage read ports with same-cycle write-through bypass, and
//   counts retired (non-bubble) instructions.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous reset, active-low
//   Instr_W    in   W-stage instruction (0 = bubble)
//   A3W        in   destination register number (0 = no write)
//   PC_W       in   PC of the W-stage instruction
//   ALUoutW    in   ALU result / load effective address
//   DMreadW    in   raw aligned data-memory word
//   A1, A2     in   D-stage read addresses
//   RD1, RD2   out  D-stage read data
//   WD_W       out  final writeback data (forwarding source)
//   WE_W       out  GRF write enable this cycle
//   RetireCnt  out  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage_grf #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [31:0]          Instr_W,
    input  logic [4:0]           A3W,
    input  logic [31:0]          PC_W,
    input  logic [31:0]          ALUoutW,
    input  logic [31:0]          DMreadW,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    output logic [31:0]          RD1,
    output logic [31:0]          RD2,
    output logic [31:0]          WD_W,
    output logic                 WE_W,
    output logic [CNT_WIDTH-1:0] RetireCnt
);

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LW,
        CLS_LB,
        CLS_LBU,
        CLS_LH,
        CLS_LHU,
        CLS_LINK
    } wb_class_e;

    wb_class_e   cls;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic [31:0]          grf_q [1:31];
    logic [CNT_WIDTH-1:0] retire_cnt_q;
    logic [CNT_WIDTH-1:0] retire_cnt_d;

    assign op    = Instr_W[31:26];
    assign funct = Instr_W[5:0];

    // Instruction class decode
    always_comb begin
        cls = CLS_ALU;
        case (op)
            6'h23:   cls = CLS_LW;
            6'h20:   cls = CLS_LB;
            6'h24:   cls = CLS_LBU;
            6'h21:   cls = CLS_LH;
            6'h25:   cls = CLS_LHU;
            6'h03:   cls = CLS_LINK;
            6'h00:   if (funct == 6'h09) cls = CLS_LINK;
            default: cls = CLS_ALU;
        endcase
    end

    // Byte/half lane selection; halfword ignores ALUoutW[0]
    always_comb begin
        byte_sel = DMreadW[7:0];
        case (ALUoutW[1:0])
            2'd0: byte_sel = DMreadW[7:0];
            2'd1: byte_sel = DMreadW[15:8];
            2'd2: byte_sel = DMreadW[23:16];
            2'd3: byte_sel = DMreadW[31:24];
            default: byte_sel = DMreadW[7:0];
        endcase
        half_sel = ALUoutW[1] ? DMreadW[31:16] : DMreadW[15:0];
    end

    // Writeback data select
    always_comb begin
        WD_W = ALUoutW;
        case (cls)
            CLS_LW:   WD_W = DMreadW;
            CLS_LB:   WD_W = {{24{byte_sel[7]}}, byte_sel};
            CLS_LBU:  WD_W = {24'd0, byte_sel};
            CLS_LH:   WD_W = {{16{half_sel[15]}}, half_sel};
            CLS_LHU:  WD_W = {16'd0, half_sel};
            CLS_LINK: WD_W = PC_W + LINK_OFFSET;
            default:  WD_W = ALUoutW;
        endcase
    end

    // Upstream forces A3W to 0 for non-writing instructions
    assign WE_W = (A3W != 5'd0);

    // Register file; r0 is not stored
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 1; i <= 31; i++) begin
                grf_q[i] <= '0;
            end
        end else if (WE_W) begin
            grf_q[A3W] <= WD_W;
        end
    end

    // Read ports with same-cycle write-through bypass
    always_comb begin
        RD1 = '0;
        if (A1 != 5'd0) begin
            if (WE_W && (A1 == A3W)) RD1 = WD_W;
            else                     RD1 = grf_q[A1];
        end
    end

    always_comb begin
        RD2 = '0;
        if (A2 != 5'd0) begin
            if (WE_W && (A2 == A3W)) RD2 = WD_W;
            else                     RD2 = grf_q[A2];
        end
    end

    // Retired-instruction counter; bubbles do not count
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (Instr_W != 32'd0) retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) retire_cnt_q <= '0;
        else        retire_cnt_q <= retire_cnt_d;
    end

    assign RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_grf.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_grf
//   Scoreboard bench for wb_stage_grf. Each applied vector pushes its expected
//   WD_W/WE_W/RD1/RD2 into a queue; the scenario task pops and compares.
//   A second instance with a 4-bit counter exercises counter wrap.
// -----------------------------------------------------------------------------
module tb_wb_stage_grf;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr_W;
    logic [4:0]  A3W;
    logic [31:0] PC_W;
    logic [31:0] ALUoutW;
    logic [31:0] DMreadW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1, RD2, WD_W;
    logic        WE_W;
    logic [31:0] RetireCnt;
    logic [31:0] RD1_4, RD2_4, WD_W_4;
    logic        WE_W_4;
    logic [3:0]  RetireCnt_4;

    wb_stage_grf #(.CNT_WIDTH(32), .LINK_OFFSET(32'd8)) u_dut (
        .Clk(Clk), .Reset(Reset), .Instr_W(Instr_W), .A3W(A3W), .PC_W(PC_W),
        .ALUoutW(ALUoutW), .DMreadW(DMreadW), .A1(A1), .A2(A2),
        .RD1(RD1), .RD2(RD2), .WD_W(WD_W), .WE_W(WE_W), .RetireCnt(RetireCnt)
    );

    wb_stage_grf #(.CNT_WIDTH(4), .LINK_OFFSET(32'd8)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .Instr_W(Instr_W), .A3W(A3W), .PC_W(PC_W),
        .ALUoutW(ALUoutW), .DMreadW(DMreadW), .A1(A1), .A2(A2),
        .RD1(RD1_4), .RD2(RD2_4), .WD_W(WD_W_4), .WE_W(WE_W_4), .RetireCnt(RetireCnt_4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] wd;
        logic        we;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } sb_t;

    sb_t         sb_q [$];
    sb_t         e;
    logic [31:0] mdl [0:31];
    logic [31:0] cur_wd;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [31:0] I_ALU  = 32'h0000_0021;  // addu
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_LB   = 32'h8000_0000;
    localparam logic [31:0] I_LBU  = 32'h9000_0000;
    localparam logic [31:0] I_LH   = 32'h8400_0000;
    localparam logic [31:0] I_LHU  = 32'h9400_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_JALR = 32'h03E0_F809;

    function automatic logic [31:0] rd_model(input logic [4:0] a, input logic [4:0] a3,
                                             input logic [31:0] wd);
        if (a == 5'd0)                  return 32'd0;
        if (a3 != 5'd0 && a == a3)      return wd;
        return mdl[a];
    endfunction

    // Drive one W-stage vector and queue its expected outputs
    task automatic apply(input logic [31:0] instr, input logic [4:0] a3, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] dm,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] exp_wd);
        sb_t s;
        Instr_W = instr; A3W = a3; PC_W = pc; ALUoutW = alu; DMreadW = dm; A1 = a1; A2 = a2;
        cur_wd = exp_wd;
        s.wd  = exp_wd;
        s.we  = (a3 != 5'd0);
        s.rd1 = Reset ? rd_model(a1, a3, exp_wd) : ((a3 != 0 && a1 == a3 && a1 != 0) ? exp_wd : 32'd0);
        s.rd2 = Reset ? rd_model(a2, a3, exp_wd) : ((a3 != 0 && a2 == a3 && a2 != 0) ? exp_wd : 32'd0);
        sb_q.push_back(s);
        #1;
    endtask

    // Advance one clock edge and update the register model
    task automatic clk_edge();
        @(posedge Clk);
        if (Reset && A3W != 5'd0) mdl[A3W] = cur_wd;
        #2;
    endtask

    task automatic reset_all();
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    endtask

    task automatic test_reset();
        reset_all();
        apply(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd31, 32'd0);
        e = sb_q.pop_front();
        n_vec++; if (RetireCnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %h want %h", RetireCnt, 32'd0); end
        n_vec++; if (RD1 !== e.rd1) begin n_err++; $display("FAIL reset_rd1: got %h want %h", RD1, e.rd1); end
        n_vec++; if (RD2 !== e.rd2) begin n_err++; $display("FAIL reset_rd2: got %h want %h", RD2, e.rd2); end
        Reset = 1'b1;
        clk_edge();
    endtask

    task automatic test_loads();
        logic [31:0] ins [6]  = '{I_LB, I_LBU, I_LH, I_LHU, I_LW, I_LB};
        logic [31:0] alu [6]  = '{32'h0000_1003, 32'h0000_1003, 32'h0000_2003, 32'h0000_2003, 32'h0000_2002, 32'h0000_0000};
        logic [31:0] dm  [6]  = '{32'h80FF_0011, 32'h80FF_0011, 32'h9ABC_1234, 32'h9ABC_1234, 32'h9ABC_1234, 32'h80FF_0011};
        logic [31:0] exp [6]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9ABC, 32'h0000_9ABC, 32'h9ABC_1234, 32'h0000_0011};
        for (int i = 0; i < 6; i++) begin
            apply(ins[i], 5'(8 + i), 32'h0000_0400, alu[i], dm[i], 5'd0, 5'd0, exp[i]);
            e = sb_q.pop_front();
            n_vec++; if (WD_W !== e.wd) begin n_err++; $display("FAIL load%0d_wd: got %h want %h", i, WD_W, e.wd); end
            n_vec++; if (WE_W !== e.we) begin n_err++; $display("FAIL load%0d_we: got %b want %b", i, WE_W, e.we); end
            clk_edge();
            apply(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'(8 + i), 5'd0, 32'd0);
            e = sb_q.pop_front();
            n_vec++; if (RD1 !== e.rd1) begin n_err++; $display("FAIL load%0d_rd: got %h want %h", i, RD1, e.rd1); end
        end
    endtask

    task automatic test_link();
        apply(I_JAL, 5'd31, 32'h0000_3004, 32'h1111_1111, 32'h0, 5'd0, 5'd0, 32'h0000_300C);
        e = sb_q.pop_front();
        n_vec++; if (WD_W !== e.wd) begin n_err++; $display("FAIL jal_wd: got %h want %h", WD_W, e.wd); end
        clk_edge();
        apply(I_JALR, 5'd30, 32'hFFFF_FFFC, 32'h2222_2222, 32'h0, 5'd0, 5'd31, 32'h0000_0004);
        e = sb_q.pop_front();
        n_vec++; if (WD_W !== e.wd) begin n_err++; $display("FAIL jalr_wd: got %h want %h", WD_W, e.wd); end
        n_vec++; if (RD2 !== 32'h0000_300C) begin n_err++; $display("FAIL jal_r31: got %h want %h", RD2, 32'h0000_300C); end
        clk_edge();
        apply(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd30, 5'd31, 32'd0);
        e = sb_q.pop_front();
        n_vec++; if (RD1 !== e.rd1) begin n_err++; $display("FAIL jalr_r30: got %h want %h", RD1, e.rd1); end
    endtask

    task automatic test_bypass();
        apply(I_ALU, 5'd7, 32'd0, 32'hDEAD_BEEF, 32'd0, 5'd7, 5'd7, 32'hDEAD_BEEF);
        e = sb_q.pop_front();
        n_vec++; if (RD1 !== e.rd1) begin n_err++; $display("FAIL byp_rd1: got %h want %h", RD1, e.rd1); end
        n_vec++; if (RD2 !== e.rd2) begin n_err++; $display("FAIL byp_rd2: got %h want %h", RD2, e.rd2); end
        clk_edge();
        apply(I_ALU, 5'd0, 32'd0, 32'h0000_0005, 32'd0, 5'd0, 5'd7, 32'h0000_0005);
        e = sb_q.pop_front();
        n_vec++; if (WE_W !== e.we) begin n_err++; $display("FAIL a3zero_we: got %b want %b", WE_W, e.we); end
        n_vec++; if (WD_W !== e.wd) begin n_err++; $display("FAIL a3zero_wd: got %h want %h", WD_W, e.wd); end
        n_vec++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL r0_rd1: got %h want %h", RD1, 32'd0); end
        n_vec++; if (RD2 !== e.rd2) begin n_err++; $display("FAIL r7_held: got %h want %h", RD2, e.rd2); end
        clk_edge();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [4:0]  a3 = 5'($urandom_range(0, 31));
            logic [31:0] v  = $urandom;
            logic [4:0]  a1 = (i % 3 == 0) ? a3 : 5'($urandom_range(0, 31));
            logic [4:0]  a2 = 5'($urandom_range(0, 31));
            apply(I_ALU, a3, 32'd0, v, 32'd0, a1, a2, v);
            e = sb_q.pop_front();
            n_vec++; if (RD1 !== e.rd1) begin n_err++; $display("FAIL b2b%0d_rd1: got %h want %h", i, RD1, e.rd1); end
            n_vec++; if (RD2 !== e.rd2) begin n_err++; $display("FAIL b2b%0d_rd2: got %h want %h", i, RD2, e.rd2); end
            clk_edge();
        end
    endtask

    task automatic test_retire();
        apply(I_ALU, 5'd5, 32'd0, 32'h0000_1234, 32'd0, 5'd0, 5'd0, 32'h0000_1234);
        void'(sb_q.pop_front());
        clk_edge();
        apply(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 32'd0);
        e = sb_q.pop_front();
        n_vec++; if (RD1 !== e.rd1) begin n_err++; $display("FAIL pre_reset_r5: got %h want %h", RD1, e.rd1); end
        #1 reset_all();
        #1;
        n_vec++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL async_rst_r5: got %h want %h", RD1, 32'd0); end
        n_vec++; if (RetireCnt !== 32'd0) begin n_err++; $display("FAIL async_rst_cnt: got %h want %h", RetireCnt, 32'd0); end
        #1 Reset = 1'b1;
        clk_edge();
        for (int i = 0; i < 6; i++) begin
            if (i == 3 || i == 4) apply(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0);
            else if (i == 5)      apply(I_ALU, 5'd0, 32'd0, 32'd9, 32'd0, 5'd0, 5'd0, 32'd9);
            else                  apply(I_ALU, 5'(i + 1), 32'd0, 32'(i), 32'd0, 5'd0, 5'd0, 32'(i));
            void'(sb_q.pop_front());
            clk_edge();
        end
        n_vec++; if (RetireCnt !== 32'd4) begin n_err++; $display("FAIL retire_cnt: got %0d want %0d", RetireCnt, 4); end
    endtask

    task automatic test_wrap();
        reset_all();
        #1 Reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            apply(I_ALU, 5'd0, 32'd0, 32'd1, 32'd0, 5'd0, 5'd0, 32'd1);
            void'(sb_q.pop_front());
            clk_edge();
        end
        n_vec++; if (RetireCnt_4 !== 4'hF) begin n_err++; $display("FAIL cnt4_full: got %h want %h", RetireCnt_4, 4'hF); end
        apply(I_ALU, 5'd0, 32'd0, 32'd1, 32'd0, 5'd0, 5'd0, 32'd1);
        void'(sb_q.pop_front());
        clk_edge();
        n_vec++; if (RetireCnt_4 !== 4'h0) begin n_err++; $display("FAIL cnt4_wrap: got %h want %h", RetireCnt_4, 4'h0); end
        n_vec++; if (RetireCnt !== 32'd16) begin n_err++; $display("FAIL cnt32_16: got %0d want %0d", RetireCnt, 16); end
    endtask

    initial begin
        Instr_W = '0; A3W = '0; PC_W = '0; ALUoutW = '0; DMreadW = '0; A1 = '0; A2 = '0;
        cur_wd = '0;
        Reset = 1'b0;
        #2;
        test_reset();
        test_loads();
        test_link();
        test_bypass();
        test_back_to_back();
        test_retire();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
